// File: rtl/axis_tpg_pkg.sv
// Shared definitions for the AXI4-Stream test-pattern generator.
// Contents: pattern mode encodings, FSM states, byte-lane order and the colour-bar table.
package axis_tpg_pkg;

    typedef enum logic [1:0] {
        TPG_SOLID = 2'd0,
        TPG_BARS  = 2'd1,
        TPG_GRAD  = 2'd2,
        TPG_CHECK = 2'd3
    } tpg_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tpg_state_e;

    // Bytes leave blue first, so lane 0 is the low byte of {R,G,B}.
    localparam logic [1:0] LANE_B = 2'd0;
    localparam logic [1:0] LANE_G = 2'd1;
    localparam logic [1:0] LANE_R = 2'd2;

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    endfunction

    function automatic logic [7:0] rgb_lane(input logic [23:0] rgb, input logic [1:0] lane);
        case (lane)
            LANE_B:  rgb_lane = rgb[7:0];
            LANE_G:  rgb_lane = rgb[15:8];
            default: rgb_lane = rgb[23:16];
        endcase
    endfunction

endpackage

// File: rtl/axis_tpg_if.sv
// AXI4-Stream byte channel between the pattern generator and its sink.
interface axis_tpg_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tstrb;
    logic       tkeep;
    logic       tlast;

    modport master (output tvalid, tdata, tstrb, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_tpg_pattern.sv
// Combinational pattern function.
// Maps (mode, fill colour, column, row) to the 24-bit {R,G,B} pixel.
module axis_tpg_pattern
    import axis_tpg_pkg::*;
#(
    parameter int COL_W = 11,
    parameter int ROW_W = 10
) (
    input  tpg_mode_e        i_mode,
    input  logic [23:0]      i_fill,
    input  logic [COL_W-1:0] i_col,
    input  logic [ROW_W-1:0] i_row,
    output logic [23:0]      o_rgb
);

    logic w_unused;
    assign w_unused = &{1'b0, i_row, i_col};

    always_comb begin
        o_rgb = i_fill;
        unique case (i_mode)
            TPG_SOLID: o_rgb = i_fill;
            // Eight equal-width bars across the full column range.
            TPG_BARS:  o_rgb = bar_rgb(i_col[COL_W-1 -: 3]);
            TPG_GRAD:  o_rgb = {3{i_col[7:0]}};
            TPG_CHECK: o_rgb = (i_col[5] ^ i_row[5]) ? 24'hFFFFFF : 24'h000000;
        endcase
    end

endmodule

// File: rtl/axis_tpg.sv
// AXI4-Stream master emitting one frame of test pattern as B,G,R bytes, row-major.
// The byte for the next beat is computed ahead so tdata/tlast come straight from flops.
module axis_tpg
    import axis_tpg_pkg::*;
#(
    parameter int H_PIXELS = 2048,
    parameter int V_LINES  = 720,
    parameter int COL_W    = 11,
    parameter int ROW_W    = 10
) (
    input  logic              axis_aclk,
    input  logic              axis_aresetn,
    input  logic              start,
    input  logic              continuous,
    input  logic [1:0]        mode,
    input  logic [23:0]       fill_rgb,
    axis_tpg_if.master        axis,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIXELS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_LINES - 1);

    tpg_state_e       r_state, w_state_nx;
    tpg_mode_e        r_mode, w_pat_mode;
    logic [23:0]      r_fill, w_pat_fill, w_rgb;
    logic [COL_W-1:0] r_col, w_col_nx;
    logic [ROW_W-1:0] r_row, w_row_nx;
    logic [1:0]       r_byte, w_byte_nx;
    logic [7:0]       r_tdata;
    logic             r_tlast, r_done;
    logic             w_hs, w_load, w_step, w_tlast_nx;

    assign w_hs = (r_state == ST_RUN) && axis.tready;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) r_state <= ST_IDLE;
        else               r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_col_nx   = r_col;
        w_row_nx   = r_row;
        w_byte_nx  = r_byte;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx = ST_RUN;
                    w_load     = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_hs && r_tlast) begin
                    if (continuous) w_load     = 1'b1;
                    else            w_state_nx = ST_IDLE;
                end else if (w_hs) begin
                    w_step = 1'b1;
                    if (r_byte == LANE_R) begin
                        w_byte_nx = LANE_B;
                        if (r_col == COL_LAST) begin
                            w_col_nx = '0;
                            w_row_nx = r_row + ROW_W'(1);
                        end else begin
                            w_col_nx = r_col + COL_W'(1);
                        end
                    end else begin
                        w_byte_nx = r_byte + 2'd1;
                    end
                end
            end
        endcase
        if (w_load) begin
            w_col_nx  = '0;
            w_row_nx  = '0;
            w_byte_nx = LANE_B;
        end
    end

    // A frame latch uses the live mode/fill so the first byte is already correct.
    assign w_pat_mode = w_load ? tpg_mode_e'(mode) : r_mode;
    assign w_pat_fill = w_load ? fill_rgb : r_fill;
    assign w_tlast_nx = (w_row_nx == ROW_LAST) && (w_col_nx == COL_LAST) && (w_byte_nx == LANE_R);

    axis_tpg_pattern #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_pattern (
        .i_mode (w_pat_mode),
        .i_fill (w_pat_fill),
        .i_col  (w_col_nx),
        .i_row  (w_row_nx),
        .o_rgb  (w_rgb)
    );

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_mode  <= TPG_SOLID;
            r_fill  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_byte  <= LANE_B;
            r_tdata <= '0;
            r_tlast <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_hs && r_tlast;
            if (w_load) begin
                r_mode <= tpg_mode_e'(mode);
                r_fill <= fill_rgb;
            end
            if (w_load || w_step) begin
                r_col   <= w_col_nx;
                r_row   <= w_row_nx;
                r_byte  <= w_byte_nx;
                r_tdata <= rgb_lane(w_rgb, w_byte_nx);
                r_tlast <= w_tlast_nx;
            end else if (w_state_nx == ST_IDLE) begin
                r_tlast <= 1'b0;
            end
        end
    end

    assign axis.tvalid = (r_state == ST_RUN);
    assign axis.tdata  = r_tdata;
    assign axis.tstrb  = 1'b1;
    assign axis.tkeep  = 1'b1;
    assign axis.tlast  = r_tlast;
    assign busy        = (r_state == ST_RUN);
    assign frame_done  = r_done;

endmodule

// File: tb/tb_axis_tpg.sv
// Bench for axis_tpg: a 4x2 instance for frame-level behaviour and a full-size
// instance for the wide patterns, both checked against a pixel-arithmetic model.
module tb_axis_tpg;

    localparam int SH = 4;
    localparam int SV = 2;
    localparam int BH = 2048;
    localparam int BV = 720;
    localparam int CW = 11;
    localparam int RW = 10;
    localparam int SMALL_BEATS = 3 * SH * SV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_s = 1'b0;
    logic        start_b = 1'b0;
    logic        cont = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] fill = 24'h0;
    logic        busy_s, done_s, busy_b, done_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] q_data[$];
    logic       q_last[$];
    int         stab_bad;
    bit         cap_timeout;

    always #5 clk = ~clk;

    axis_tpg_if s_if();
    axis_tpg_if b_if();

    axis_tpg #(.H_PIXELS(SH), .V_LINES(SV), .COL_W(CW), .ROW_W(RW)) u_small (
        .axis_aclk(clk), .axis_aresetn(rst_n), .start(start_s), .continuous(cont),
        .mode(mode), .fill_rgb(fill), .axis(s_if.master), .busy(busy_s), .frame_done(done_s));

    axis_tpg #(.H_PIXELS(BH), .V_LINES(BV), .COL_W(CW), .ROW_W(RW)) u_big (
        .axis_aclk(clk), .axis_aresetn(rst_n), .start(start_b), .continuous(1'b0),
        .mode(mode), .fill_rgb(fill), .axis(b_if.master), .busy(busy_b), .frame_done(done_b));

    function automatic logic [23:0] bar_color(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected byte k of a frame of width h, from the pixel arithmetic alone.
    function automatic logic [7:0] model_byte(input int m, input logic [23:0] f, input int k, input int h);
        int pix, col, row, b;
        logic [23:0] rgb;
        logic [7:0] g;
        pix = k / 3;
        b   = k % 3;
        col = pix % h;
        row = pix / h;
        case (m)
            0: rgb = f;
            1: rgb = bar_color(col / (2 ** (CW - 3)));
            2: begin
                g = 8'(col % 256);
                rgb = {g, g, g};
            end
            default: rgb = (((col / 32) % 2) != ((row / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
        endcase
        return 8'((rgb >> (8 * b)) & 24'hFF);
    endfunction

    task automatic pulse_start_s();
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
    endtask

    // Collects beats from the small instance until the TLAST handshake (or timeout).
    task automatic capture(input int ready_pct, input int max_cyc, input bit start_on_last);
        logic [7:0] pd;
        logic       pl;
        bit         stall;
        bit         got_last;
        int         cyc;
        stall = 0; got_last = 0; cyc = 0; pd = '0; pl = 1'b0;
        q_data.delete(); q_last.delete(); stab_bad = 0; cap_timeout = 0;
        while (!got_last && cyc < max_cyc) begin
            s_if.tready = ($urandom_range(99) < ready_pct);
            if (stall && (s_if.tvalid !== 1'b1 || s_if.tdata !== pd || s_if.tlast !== pl)) stab_bad++;
            stall = s_if.tvalid && !s_if.tready;
            pd = s_if.tdata;
            pl = s_if.tlast;
            if (s_if.tvalid && s_if.tready) begin
                q_data.push_back(s_if.tdata);
                q_last.push_back(s_if.tlast);
                if (s_if.tlast) begin
                    got_last = 1;
                    if (start_on_last) start_s = 1'b1;
                end
            end
            @(posedge clk); #1;
            start_s = 1'b0;
            cyc++;
        end
        cap_timeout = !got_last;
    endtask

    task automatic check_frame(input string tag, input int m, input logic [23:0] f);
        n_cmp++;
        if (cap_timeout || q_data.size() !== SMALL_BEATS) begin
            n_bad++;
            $display("FAIL %s_count: got %0d beats (timeout=%0d), want %0d", tag, q_data.size(), cap_timeout, SMALL_BEATS);
        end
        for (int i = 0; i < q_data.size(); i++) begin
            n_cmp++;
            if (q_data[i] !== model_byte(m, f, i, SH) || q_last[i] !== (i == SMALL_BEATS - 1)) begin
                n_bad++;
                $display("FAIL %s_beat%0d: got data %h last %b, want data %h last %b", tag, i,
                         q_data[i], q_last[i], model_byte(m, f, i, SH), (i == SMALL_BEATS - 1));
            end
        end
    endtask

    task automatic test_reset();
        s_if.tready = 1'b1; b_if.tready = 1'b1;
        #2 rst_n = 1'b0;
        start_s = 1'b1; start_b = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({s_if.tvalid, busy_s, done_s, b_if.tvalid, busy_b, done_b} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_ctrl: got %b, want 000000",
                         {s_if.tvalid, busy_s, done_s, b_if.tvalid, busy_b, done_b});
            end
        end
        n_cmp++;
        if (s_if.tdata !== 8'h00 || s_if.tlast !== 1'b0 || s_if.tstrb !== 1'b1 || s_if.tkeep !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_data: got tdata %h tlast %b tstrb %b tkeep %b, want 00 0 1 1",
                     s_if.tdata, s_if.tlast, s_if.tstrb, s_if.tkeep);
        end
        start_s = 1'b0; start_b = 1'b0;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            n_cmp++;
            if (s_if.tvalid !== 1'b0 || busy_s !== 1'b0 || b_if.tvalid !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_after_reset: got tvalid %b busy %b big_tvalid %b, want 0 0 0",
                         s_if.tvalid, busy_s, b_if.tvalid);
            end
        end
    endtask

    task automatic test_frame();
        logic [23:0] f;
        f = 24'($urandom);
        mode = 2'd2; fill = f; cont = 1'b0;
        pulse_start_s();
        n_cmp++;
        if (s_if.tvalid !== 1'b1 || busy_s !== 1'b1) begin
            n_bad++;
            $display("FAIL first_latency: got tvalid %b busy %b, want 1 1", s_if.tvalid, busy_s);
        end
        capture(100, 100, 0);
        check_frame("grad", 2, f);
        n_cmp++;
        if (done_s !== 1'b1 || s_if.tvalid !== 1'b0 || busy_s !== 1'b0) begin
            n_bad++;
            $display("FAIL end_of_frame: got done %b tvalid %b busy %b, want 1 0 0", done_s, s_if.tvalid, busy_s);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done_s !== 1'b0) begin
            n_bad++;
            $display("FAIL done_width: got %b, want 0", done_s);
        end
    endtask

    task automatic test_modes();
        int m;
        logic [23:0] f;
        for (int it = 0; it < 4; it++) begin
            m = it; f = 24'($urandom);
            mode = 2'(m); fill = f;
            pulse_start_s();
            mode = 2'($urandom); fill = 24'($urandom);
            capture(100, 100, 0);
            check_frame("mode", m, f);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int m;
        logic [23:0] f;
        for (int it = 0; it < 4; it++) begin
            m = (it == 0) ? 2 : int'($urandom_range(3));
            f = 24'($urandom);
            mode = 2'(m); fill = f;
            pulse_start_s();
            capture(50, 400, 0);
            check_frame("bp", m, f);
            n_cmp++;
            if (stab_bad !== 0) begin
                n_bad++;
                $display("FAIL bp_stable: got %0d unstable stalled cycles, want 0", stab_bad);
            end
            s_if.tready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_at_last();
        mode = 2'd2; fill = 24'h0; cont = 1'b0;
        pulse_start_s();
        capture(100, 100, 1);
        check_frame("start_last", 2, 24'h0);
        repeat (3) begin
            n_cmp++;
            if (s_if.tvalid !== 1'b0 || busy_s !== 1'b0) begin
                n_bad++;
                $display("FAIL start_at_last_ignored: got tvalid %b busy %b, want 0 0", s_if.tvalid, busy_s);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_continuous();
        mode = 2'd0; fill = 24'h123456; cont = 1'b1;
        pulse_start_s();
        fill = 24'hABCDEF;
        capture(100, 100, 0);
        check_frame("cont1", 0, 24'h123456);
        n_cmp++;
        if (s_if.tvalid !== 1'b1 || s_if.tdata !== 8'hEF || done_s !== 1'b1) begin
            n_bad++;
            $display("FAIL cont_no_bubble: got tvalid %b tdata %h done %b, want 1 ef 1", s_if.tvalid, s_if.tdata, done_s);
        end
        cont = 1'b0;
        capture(100, 100, 0);
        check_frame("cont2", 0, 24'hABCDEF);
        n_cmp++;
        if (s_if.tvalid !== 1'b0 || done_s !== 1'b1) begin
            n_bad++;
            $display("FAIL cont_stop: got tvalid %b done %b, want 0 1", s_if.tvalid, done_s);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int beats;
        int m;
        logic [23:0] f;
        beats = 0;
        mode = 2'd2; fill = 24'h0;
        pulse_start_s();
        for (int c = 0; c < 50 && beats < 10; c++) begin
            s_if.tready = $urandom_range(1);
            if (s_if.tvalid && s_if.tready) beats++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (beats !== 10 || s_if.tvalid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reach: got %0d beats tvalid %b, want 10 1", beats, s_if.tvalid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (s_if.tvalid !== 1'b0 || busy_s !== 1'b0 || s_if.tlast !== 1'b0 || s_if.tdata !== 8'h00) begin
            n_bad++;
            $display("FAIL async_reset: got tvalid %b busy %b tlast %b tdata %h, want 0 0 0 00",
                     s_if.tvalid, busy_s, s_if.tlast, s_if.tdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        m = int'($urandom_range(3)); f = 24'($urandom);
        mode = 2'(m); fill = f;
        pulse_start_s();
        capture(70, 400, 0);
        check_frame("restart", m, f);
        @(posedge clk); #1;
    endtask

    task automatic test_big_patterns();
        int m;
        logic [23:0] f;
        logic [7:0] exp_b;
        b_if.tready = 1'b1;
        for (int it = 0; it < 4; it++) begin
            m = (it + 1) % 4;
            f = 24'($urandom);
            mode = 2'(m); fill = f;
            start_b = 1'b1;
            @(posedge clk); #1;
            start_b = 1'b0;
            for (int k = 0; k < 5400; k++) begin
                exp_b = model_byte(m, f, k, BH);
                n_cmp++;
                if (b_if.tvalid !== 1'b1 || b_if.tdata !== exp_b || b_if.tlast !== 1'b0) begin
                    n_bad++;
                    $display("FAIL big_m%0d_beat%0d: got valid %b data %h last %b, want 1 %h 0",
                             m, k, b_if.tvalid, b_if.tdata, b_if.tlast, exp_b);
                end
                if (m == 1 && (k == 768 || k == 770 || k == 5376)) begin
                    n_cmp++;
                    if (b_if.tdata !== ((k == 770) ? 8'hFF : 8'h00)) begin
                        n_bad++;
                        $display("FAIL bars_spot%0d: got %h, want %h", k, b_if.tdata, (k == 770) ? 8'hFF : 8'h00);
                    end
                end
                @(posedge clk); #1;
            end
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_modes();
        test_backpressure();
        test_start_at_last();
        test_continuous();
        test_reset_mid();
        test_big_patterns();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
